// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage: PC owner, in-order imem requester,
// small fetch queue feeding IF/ID with NOP bubbles, stall hold and redirect squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic [31:0] pc_plus4_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      fpc;
  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [DEPTH-1:0] q_rdy;
  logic [AW-1:0]    head;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    pend;
  logic [CW-1:0]    kill;

  logic [AW-1:0]    tail;
  logic [AW-1:0]    rsp_slot;
  logic [CW:0]      inflight;
  logic             accept;
  logic             rsp_live;
  logic             rsp_drop;
  logic             pop;

  // Unready slots are always the youngest allocated ones, so the next
  // response lands pend slots behind the tail.
  assign tail     = head + occ[AW-1:0];
  assign rsp_slot = tail - pend[AW-1:0];
  assign inflight = {1'b0, occ} + {1'b0, kill};

  assign imem_req_valid = !rst && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fpc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (kill != '0);
  assign rsp_live       = imem_rsp_valid && (kill == '0) && (pend != '0);

  assign fetch_valid = !rst && (occ != '0) && q_rdy[head];
  assign pop         = fetch_valid && !stall && !redirect;
  assign pc_if       = fetch_valid ? q_pc[head] : 32'h0;
  assign instr_if    = fetch_valid ? q_instr[head] : NOP;
  assign pc_plus4_if = fetch_valid ? q_pc[head] + 32'd4 : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc   <= RESET_PC;
      head  <= '0;
      occ   <= '0;
      pend  <= '0;
      kill  <= '0;
      q_rdy <= '0;
    end else if (redirect) begin
      // Every still-outstanding live request becomes a beat to discard.
      fpc   <= redirect_pc & ~32'h3;
      occ   <= '0;
      pend  <= '0;
      q_rdy <= '0;
      kill  <= kill + pend - CW'(rsp_drop || rsp_live);
    end else begin
      if (accept) begin
        q_pc[tail]  <= fpc;
        q_rdy[tail] <= 1'b0;
        fpc         <= fpc + 32'd4;
      end
      if (rsp_live) begin
        q_instr[rsp_slot] <= imem_rsp_data;
        q_rdy[rsp_slot]   <= 1'b1;
      end
      if (rsp_drop)
        kill <= kill - CW'(1);
      if (pop)
        head <= head + AW'(1);
      occ  <= occ + CW'(accept) - CW'(pop);
      pend <= pend + CW'(accept) - CW'(rsp_live);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against an in-order fetch stream model
// and a variable-latency instruction memory.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_valid;
  logic [31:0] pc_if, instr_if, pc_plus4_if;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .fetch_valid(fetch_valid), .pc_if(pc_if), .instr_if(instr_if), .pc_plus4_if(pc_plus4_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_consumed = 0;
  logic [31:0] exp_pc, exp_addr, last_cons_pc, wrap_pc4, held;
  logic        prev_pending, wrap_seen;
  logic [31:0] mq_addr [$];
  int          mq_due [$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs just after the edge, check and advance the model at the falling edge.
  task automatic cycle(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input int k);
    @(posedge clk);
    #1;
    cyc++;
    rst = r; stall = st; redirect = rd; redirect_pc = rpc; imem_req_ready = rdy;
    if (!r && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    if (r) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_fetch_valid", fetch_valid, 0);
      chk("rst_instr", instr_if, NOP);
      chk("rst_pc", pc_if, 0);
      chk("rst_pc4", pc_plus4_if, 0);
      mq_addr.delete();
      mq_due.delete();
      exp_pc = RST_PC;
      exp_addr = RST_PC;
      prev_pending = 1'b0;
    end else begin
      if (prev_pending && !imem_req_valid)
        chk("req_retract_only_on_redirect", redirect, 1);
      if (redirect)
        chk("no_req_on_redirect", imem_req_valid, 0);
      if (fetch_valid) begin
        chk("head_pc", pc_if, exp_pc);
        chk("head_instr", instr_if, instr_of(exp_pc));
        chk("head_pc4", pc_plus4_if, exp_pc + 32'd4);
        if (exp_pc == 32'hFFFF_FFFC) begin
          wrap_seen = 1'b1;
          wrap_pc4 = pc_plus4_if;
        end
        if (!stall && !redirect) begin
          last_cons_pc = exp_pc;
          exp_pc += 32'd4;
          n_consumed++;
        end
      end else begin
        chk("bubble_instr", instr_if, NOP);
        chk("bubble_pc", pc_if, 0);
        chk("bubble_pc4", pc_plus4_if, 0);
      end
      if (imem_rsp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_addr);
        mq_addr.push_back(exp_addr);
        mq_due.push_back(cyc + k);
        exp_addr += 32'd4;
        chk("outstanding_le_depth", 32'(mq_addr.size() <= DEPTH), 1);
      end
      if (redirect) begin
        exp_pc = redirect_pc & ~32'h3;
        exp_addr = redirect_pc & ~32'h3;
      end
      prev_pending = imem_req_valid && !imem_req_ready;
    end
  endtask

  initial begin
    int nv;
    int n0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    prev_pending = 1'b0; wrap_seen = 1'b0; wrap_pc4 = 32'hDEAD_BEEF; last_cons_pc = '0;
    exp_pc = RST_PC; exp_addr = RST_PC;

    repeat (2) cycle(1, 0, 0, 0, 1, 1);

    // First fetch latency with k=1.
    cycle(0, 0, 0, 0, 1, 1);
    chk("c1_req_valid", imem_req_valid, 1);
    chk("c1_req_addr", imem_req_addr, 32'h100);
    chk("c1_fetch_valid", fetch_valid, 0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("c2_fetch_valid", fetch_valid, 0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("c3_fetch_valid", fetch_valid, 1);
    chk("c3_pc", pc_if, 32'h100);

    nv = 0;
    repeat (20) begin
      cycle(0, 0, 0, 0, 1, 1);
      nv += int'(fetch_valid);
    end
    chk("throughput_k1", nv, 20);

    // Stall for 5 cycles while the queue fills.
    cycle(0, 1, 0, 0, 1, 1);
    held = pc_if;
    repeat (4) begin
      cycle(0, 1, 0, 0, 1, 1);
      chk("stall_hold_pc", pc_if, held);
    end
    chk("stall_full_req_drop", imem_req_valid, 0);
    chk("stall_full_fetch_valid", fetch_valid, 1);
    repeat (10) cycle(0, 0, 0, 0, 1, 1);

    // Redirect with k=2 requests in flight.
    repeat (10) cycle(0, 0, 0, 0, 1, 2);
    cycle(0, 0, 1, 32'h0000_2003, 1, 2);
    cycle(0, 0, 0, 0, 1, 2);
    chk("redir_req_addr", imem_req_addr, 32'h2000);
    n0 = n_consumed;
    for (int i = 0; i < 12 && n_consumed == n0; i++)
      cycle(0, 0, 0, 0, 1, 2);
    chk("redir_first_pc", last_cons_pc, 32'h2000);

    // Redirect together with stall while a live response is arriving.
    repeat (6) cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 1, 1, 32'h0000_3000, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("rs_fetch_valid", fetch_valid, 0);
    chk("rs_instr_nop", instr_if, NOP);
    chk("rs_pc_zero", pc_if, 0);

    // Address wrap at the top of the address space.
    wrap_seen = 1'b0;
    cycle(0, 0, 1, 32'hFFFF_FFF8, 1, 1);
    repeat (8) cycle(0, 0, 0, 0, 1, 1);
    chk("wrap_seen", wrap_seen, 1);
    chk("wrap_pc4", wrap_pc4, 0);

    // Randomized traffic: backpressure, mixed latency, stalls, redirects, rare resets.
    n0 = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 600) == 0, ($urandom % 4) == 0, ($urandom % 32) == 0, $urandom,
            ($urandom % 4) != 0, 1 + int'($urandom % 2));
    end
    chk("rand_progress", 32'((n_consumed - n0) > 200), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
